// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path constants and the FIFO operation encoding.
package uart_rx_fifo_pkg;

   localparam int unsigned UART_DEPTH_LOG2 = 4;
   localparam int unsigned UART_DATA_W     = 8;
   localparam logic [7:0]  UART_IDLE_BYTE  = 8'h00;

   // Bit 1 = accepted write, bit 0 = accepted read.
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bundle of the receiver-FIFO byte/strobe/status signals with producer and FIFO views.
interface uart_rx_fifo_if
   import uart_rx_fifo_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = UART_DEPTH_LOG2,
   parameter int unsigned DATA_W     = UART_DATA_W
);
   logic [DATA_W-1:0]   din;
   logic                wr_stb;
   logic                rd_stb;
   logic                clr_ovr_stb;
   logic [DATA_W-1:0]   dout;
   logic                empty;
   logic                full;
   logic [DEPTH_LOG2:0] count;
   logic                overrun;
   logic                irq;

   modport master (
      output din, wr_stb, rd_stb, clr_ovr_stb,
      input  dout, empty, full, count, overrun, irq
   );

   modport slave (
      input  din, wr_stb, rd_stb, clr_ovr_stb,
      output dout, empty, full, count, overrun, irq
   );

endinterface

// File: rtl/uart_fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous read port, no reset on contents.
module uart_fifo_mem #(
   parameter int unsigned AW = 4,
   parameter int unsigned DW = 8
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [2**AW];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver and the CPU: pointers, count, sticky overrun, irq.
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = UART_DEPTH_LOG2,
   parameter int unsigned DATA_W     = UART_DATA_W
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic [DATA_W-1:0]   din_i,
   input  logic                wr_stb_i,
   input  logic                rd_stb_i,
   input  logic                clr_ovr_stb_i,
   output logic [DATA_W-1:0]   dout_o,
   output logic                empty_o,
   output logic                full_o,
   output logic [DEPTH_LOG2:0] count_o,
   output logic                overrun_o,
   output logic                irq_o
);

   localparam int unsigned        CNT_W    = DEPTH_LOG2 + 1;
   localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(2**DEPTH_LOG2);

   logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
   logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  ovr_q, ovr_d;
   logic                  empty, full;
   logic                  rd_acc, wr_acc, drop;
   logic [DATA_W-1:0]     rdata;
   fifo_op_e              op;

   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_CNT);

   // A pop in the same cycle frees the slot, so a write while full is still taken.
   assign rd_acc = rd_stb_i & ~empty;
   assign wr_acc = wr_stb_i & (~full | rd_acc);
   assign drop   = wr_stb_i & full & ~rd_acc;

   always_comb begin
      op      = fifo_op_e'({wr_acc, rd_acc});
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      case (op)
         OP_PUSH: begin
            wptr_d  = wptr_q + DEPTH_LOG2'(1);
            count_d = count_q + CNT_W'(1);
         end
         OP_POP: begin
            rptr_d  = rptr_q + DEPTH_LOG2'(1);
            count_d = count_q - CNT_W'(1);
         end
         OP_BOTH: begin
            wptr_d  = wptr_q + DEPTH_LOG2'(1);
            rptr_d  = rptr_q + DEPTH_LOG2'(1);
         end
         default: ;
      endcase
      ovr_d = drop | (ovr_q & ~clr_ovr_stb_i);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
         ovr_q   <= 1'b0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
         ovr_q   <= ovr_d;
      end
   end

   uart_fifo_mem #(
      .AW (DEPTH_LOG2),
      .DW (DATA_W)
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (wr_acc),
      .waddr_i (wptr_q),
      .wdata_i (din_i),
      .raddr_i (rptr_q),
      .rdata_o (rdata)
   );

   // Stale storage stays hidden: the head is forced to the idle byte when empty.
   assign dout_o    = empty ? DATA_W'(UART_IDLE_BYTE) : rdata;
   assign empty_o   = empty;
   assign full_o    = full;
   assign count_o   = count_q;
   assign overrun_o = ovr_q;
   assign irq_o     = ~empty | ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: driver queues accepted bytes, monitor checks each pop.
module tb_uart_rx_fifo;

   localparam int DL2   = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   uart_rx_fifo_if #(.DEPTH_LOG2(DL2), .DATA_W(DW)) bus ();

   uart_rx_fifo #(.DEPTH_LOG2(DL2), .DATA_W(DW)) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .din_i         (bus.din),
      .wr_stb_i      (bus.wr_stb),
      .rd_stb_i      (bus.rd_stb),
      .clr_ovr_stb_i (bus.clr_ovr_stb),
      .dout_o        (bus.dout),
      .empty_o       (bus.empty),
      .full_o        (bus.full),
      .count_o       (bus.count),
      .overrun_o     (bus.overrun),
      .irq_o         (bus.irq)
   );

   logic [7:0] sb [$];
   logic       exp_ovr = 1'b0;
   int         n_tests = 0;
   int         n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_state();
      chk("count",    32'(bus.count),   32'(sb.size()));
      chk("empty",    32'(bus.empty),   32'(sb.size() == 0));
      chk("full",     32'(bus.full),    32'(sb.size() == DEPTH));
      chk("overrun",  32'(bus.overrun), 32'(exp_ovr));
      chk("irq",      32'(bus.irq),     32'((sb.size() != 0) || exp_ovr));
      if (sb.size() == 0) chk("dout_idle", 32'(bus.dout), 32'h0);
      else                chk("dout_head", 32'(bus.dout), 32'(sb[0]));
   endtask

   // One clock of stimulus; called at posedge+1 so the monitor sees stable inputs at negedge.
   task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c,
                       input logic rst);
      int   sz = sb.size();
      logic acc;
      bus.wr_stb      = w;
      bus.din         = d;
      bus.rd_stb      = r;
      bus.clr_ovr_stb = c;
      rst_n           = ~rst;
      if (!rst) begin
         acc = w && ((sz < DEPTH) || (r && sz > 0));
         if (acc) sb.push_back(d);
         exp_ovr = (w && !acc) | (exp_ovr & ~c);
      end
      @(posedge clk);
      #1;
      bus.wr_stb      = 1'b0;
      bus.din         = '0;
      bus.rd_stb      = 1'b0;
      bus.clr_ovr_stb = 1'b0;
      rst_n           = 1'b1;
      if (rst) begin
         sb.delete();
         exp_ovr = 1'b0;
      end
      check_state();
   endtask

   initial begin : monitor
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.rd_stb && !bus.empty) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL pop_unexpected: got 0x%0h, expected no entry", bus.dout);
            end else begin
               e = sb.pop_front();
               chk("pop_data", 32'(bus.dout), 32'(e));
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      bus.din = '0; bus.wr_stb = 1'b0; bus.rd_stb = 1'b0; bus.clr_ovr_stb = 1'b0;
      @(posedge clk); #1;
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_empty", 32'(bus.empty), 32'd1);
      chk("rst_full",  32'(bus.full),  32'd0);
      chk("rst_ovr",   32'(bus.overrun), 32'd0);
      chk("rst_irq",   32'(bus.irq),   32'd0);
      chk("rst_dout",  32'(bus.dout),  32'h00);

      // Single write then pop
      step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
      chk("s1_dout",  32'(bus.dout),  32'h41);
      chk("s1_empty", 32'(bus.empty), 32'd0);
      chk("s1_count", 32'(bus.count), 32'd1);
      chk("s1_irq",   32'(bus.irq),   32'd1);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("s1_pop_empty", 32'(bus.empty), 32'd1);
      chk("s1_pop_dout",  32'(bus.dout),  32'h00);
      chk("s1_pop_irq",   32'(bus.irq),   32'd0);

      // Fill, overflow, drain in order
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      chk("s2_full",  32'(bus.full),  32'd1);
      chk("s2_count", 32'(bus.count), 32'd16);
      step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
      chk("s2_ovr",   32'(bus.overrun), 32'd1);
      chk("s2_count_after_drop", 32'(bus.count), 32'd16);
      for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("s2_drained", 32'(bus.empty), 32'd1);
      chk("s2_ovr_sticky", 32'(bus.overrun), 32'd1);
      chk("s2_irq_ovr", 32'(bus.irq), 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("s2_ovr_clr", 32'(bus.overrun), 32'd0);

      // Overrun set beats a same-cycle clear
      for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
      chk("setwins_ovr", 32'(bus.overrun), 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("setwins_clr", 32'(bus.overrun), 32'd0);

      // Full with simultaneous write and pop
      step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
      chk("s3_count", 32'(bus.count), 32'd16);
      chk("s3_ovr",   32'(bus.overrun), 32'd0);
      for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("s3_last_dout",  32'(bus.dout),  32'h55);
      chk("s3_last_count", 32'(bus.count), 32'd1);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // Empty with simultaneous write and pop, then pop while empty
      step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
      chk("s4_count", 32'(bus.count), 32'd1);
      chk("s4_dout",  32'(bus.dout),  32'h33);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("s4_idle_count", 32'(bus.count), 32'd0);
      chk("s4_idle_empty", 32'(bus.empty), 32'd1);
      chk("s4_idle_dout",  32'(bus.dout),  32'h00);

      // Streaming write+pop across pointer wraps
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0, 1'b0);
         chk("s5_count", 32'(bus.count), 32'd3);
      end
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // Reset mid-operation with a same-cycle write
      for (int i = 0; i < 16; i++) step(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("s6_pre_count", 32'(bus.count), 32'd5);
      chk("s6_pre_ovr",   32'(bus.overrun), 32'd1);
      step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
      chk("s6_count", 32'(bus.count), 32'd0);
      chk("s6_ovr",   32'(bus.overrun), 32'd0);
      chk("s6_empty", 32'(bus.empty), 32'd1);
      chk("s6_dout",  32'(bus.dout),  32'h00);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("s6_still_empty", 32'(bus.empty), 32'd1);
      step(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
      chk("s6_post_dout", 32'(bus.dout), 32'h12);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
